// File: rtl/input_mat_pingpong_bank.sv
// Double-buffered input-matrix register bank for the systolic array: one bank
// fills from row-major beats while the other is presented whole until released.

module input_mat_bank_regs #(
  parameter int MAT_W  = 512,
  parameter int SLOT_W = 32,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [CW-1:0]     slot,
  input  logic [SLOT_W-1:0] wdata,
  output logic [MAT_W-1:0]  q
);
  // Row-major layout means beat n lands at flat element n*BEAT_ELEMS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q[slot*SLOT_W +: SLOT_W] <= wdata;
  end
endmodule

module input_mat_pingpong_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BEAT_ELEMS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BEAT_ELEMS*DATA_WIDTH-1:0] in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_release,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] out_data,
  output logic                            out_bank,
  output logic                            err_frame
);
  localparam int BEATS = ROWS*COLS/BEAT_ELEMS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BW    = BEAT_ELEMS*DATA_WIDTH;
  localparam int MW    = ROWS*COLS*DATA_WIDTH;

  logic [1:0]         full;
  logic               wr_bank, rd_bank;
  logic [CW-1:0]      beat_cnt;
  logic [1:0][MW-1:0] bank_q;
  logic               accept, last_beat, release_ok;

  assign in_ready   = !full[wr_bank] && !clear;
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt == CW'(BEATS-1));
  assign release_ok = out_release && full[rd_bank];

  assign out_valid = full[rd_bank];
  assign out_bank  = rd_bank;
  assign out_data  = bank_q[rd_bank];

  // Release and completion never target the same bank (accept needs
  // wr_bank empty, release needs rd_bank full), so both may land together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      beat_cnt  <= '0;
      err_frame <= 1'b0;
    end else if (clear) begin
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      beat_cnt  <= '0;
      err_frame <= 1'b0;
    end else begin
      if (release_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (accept) begin
        if (last_beat) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          beat_cnt      <= '0;
          if (!in_last) err_frame <= 1'b1;
        end else if (in_last) begin
          // Early last: restart the same bank, partial data gets overwritten.
          err_frame <= 1'b1;
          beat_cnt  <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    input_mat_bank_regs #(.MAT_W(MW), .SLOT_W(BW), .CW(CW)) u_regs (
      .clk   (clk),
      .reset (reset),
      .we    (accept && (wr_bank == 1'(b))),
      .slot  (beat_cnt),
      .wdata (in_data),
      .q     (bank_q[b])
    );
  end
endmodule
